// File: rtl/pi_arbiter_rr.sv
// pi_arbiter_rr: registered round-robin pi-switch arbiter for one BFT tree node.
// Routes inputs L, R, UL, UR onto outputs L, R, UL, UR with priority
// turnback > downlink > side link > uplink > void fill. Side-input ordering is
// starvation aware: the input with more recent deflections goes first, and on a
// tie a round-robin pointer decides. All outputs are registered (1-cycle latency).
// defl_vec is packed {L, R, UL, UR}, so input L is bit 3.
// Optional build macro PI_ARB_LFSR_EN: when defined, the up-port swap bit comes
// from a Galois LFSR; otherwise it is a simple toggle register.
module pi_arbiter_rr #(
    parameter int                LEVEL     = 1,
    parameter int                CNT_W     = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] d_l,
    input  logic [1:0] d_r,
    input  logic [1:0] d_ul,
    input  logic [1:0] d_ur,
    output logic [1:0] sel_l,
    output logic [1:0] sel_r,
    output logic [1:0] sel_ul,
    output logic [1:0] sel_ur,
    output logic [3:0] defl_vec,
    output logic       swap
);

    // direction requests
    localparam logic [1:0] D_VOID  = 2'b00;
    localparam logic [1:0] D_LEFT  = 2'b01;
    localparam logic [1:0] D_RIGHT = 2'b10;
    localparam logic [1:0] D_UP    = 2'b11;
    // mux selects (which input drives an output)
    localparam logic [1:0] S_LEFT  = 2'b01;
    localparam logic [1:0] S_RIGHT = 2'b10;
    localparam logic [1:0] S_UPL   = 2'b11;
    localparam logic [1:0] S_UPR   = 2'b00;
    // internal port slots; input i's "own" slot is slot i
    localparam logic [1:0] P_L  = 2'd0;
    localparam logic [1:0] P_R  = 2'd1;
    localparam logic [1:0] P_U1 = 2'd2;
    localparam logic [1:0] P_U2 = 2'd3;
    localparam logic [3:0][1:0] ICODE = {S_UPR, S_UPL, S_RIGHT, S_LEFT};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (LEVEL < 0 || CNT_W < 1 || LFSR_W < 2 || LFSR_TAPS == '0 ||
        $bits(LFSR_SEED) != LFSR_W) begin : g_param_check
        $error("pi_arbiter_rr: illegal parameter set");
    end

    logic [CNT_W-1:0] cnt_l, cnt_r;
    logic             rr_ptr;
    logic             swap_cur;
    logic             up_active;
    logic [3:0][1:0]  din;
    logic [3:0][1:0]  psel;
    logic [3:0]       pfree;
    logic [3:0]       defl;
    logic             ul_down;
    logic [1:0]       ul_tgt, tgt, si, dst, cand;
    logic             first_r, s, got;
    logic [1:0]       want;

    assign din = {d_ur, d_ul, d_r, d_l};

    // Fallback slot order for a side input s (0=L, 1=R) in the side-link or uplink phase.
    function automatic logic [1:0] fb_port(input logic uplink, input logic sd, input logic [1:0] j);
        logic [1:0] own, opp;
        own = {1'b0, sd};
        opp = {1'b0, ~sd};
        if (!uplink) begin
            case (j)
                2'd0:    fb_port = opp;
                2'd1:    fb_port = own;
                2'd2:    fb_port = P_U1;
                default: fb_port = P_U2;
            endcase
        end else begin
            case (j)
                2'd0:    fb_port = P_U1;
                2'd1:    fb_port = P_U2;
                2'd2:    fb_port = own;
                default: fb_port = opp;
            endcase
        end
    endfunction

    // Allocation: fill slots phase by phase; every input ends up in exactly one slot.
    always_comb begin
        psel    = '0;
        pfree   = 4'b1111;
        defl    = '0;
        ul_down = 1'b0;
        ul_tgt  = '0;
        tgt     = '0;
        s       = 1'b0;
        si      = '0;
        want    = '0;
        got     = 1'b0;
        dst     = '0;
        cand    = '0;

        // turnback
        if (d_l == D_LEFT)  begin psel[P_L]  = S_LEFT;  pfree[P_L]  = 1'b0; end
        if (d_r == D_RIGHT) begin psel[P_R]  = S_RIGHT; pfree[P_R]  = 1'b0; end
        if (d_ul == D_UP)   begin psel[P_U1] = S_UPL;   pfree[P_U1] = 1'b0; end
        if (d_ur == D_UP)   begin psel[P_U2] = S_UPR;   pfree[P_U2] = 1'b0; end

        // downlinks: UL resolves first, so it wins a shared side port
        if (d_ul == D_LEFT || d_ul == D_RIGHT) begin
            ul_tgt = (d_ul == D_LEFT) ? P_L : P_R;
            if (pfree[ul_tgt]) begin
                psel[ul_tgt]  = S_UPL;
                pfree[ul_tgt] = 1'b0;
                ul_down       = 1'b1;
            end else begin
                psel[P_U1]  = S_UPL;
                pfree[P_U1] = 1'b0;
                defl[2]     = 1'b1;
            end
        end
        if (d_ur == D_LEFT || d_ur == D_RIGHT) begin
            tgt = (d_ur == D_LEFT) ? P_L : P_R;
            if (pfree[tgt]) begin
                psel[tgt]  = S_UPR;
                pfree[tgt] = 1'b0;
            end else if (ul_down && ul_tgt == tgt) begin
                // lost the port to UL; UL is not going up, so u1 is free
                psel[P_U1]  = S_UPR;
                pfree[P_U1] = 1'b0;
                defl[3]     = 1'b1;
            end else begin
                psel[P_U2]  = S_UPR;
                pfree[P_U2] = 1'b0;
                defl[3]     = 1'b1;
            end
        end

        // side links (ph=0) then uplinks (ph=1); the starved side goes first
        first_r = (cnt_r > cnt_l) || ((cnt_r == cnt_l) && rr_ptr);
        for (int ph = 0; ph < 2; ph++) begin
            for (int k = 0; k < 2; k++) begin
                s    = first_r ^ k[0];
                si   = {1'b0, s};
                want = s ? d_r : d_l;
                if ((ph == 0 && want == (s ? D_LEFT : D_RIGHT)) || (ph == 1 && want == D_UP)) begin
                    got = 1'b0;
                    dst = '0;
                    for (int j = 0; j < 4; j++) begin
                        cand = fb_port(ph[0], s, 2'(j));
                        if (!got && pfree[cand]) begin
                            psel[cand]  = ICODE[si];
                            pfree[cand] = 1'b0;
                            dst         = cand;
                            got         = 1'b1;
                        end
                    end
                    defl[si] = (ph == 0) ? (dst != {1'b0, ~s}) : !dst[1];
                end
            end
        end

        up_active = ~(pfree[P_U1] & pfree[P_U2]);

        // void fill: own slot if still free, otherwise the first free slot
        for (int i = 0; i < 4; i++) begin
            if (din[i] == D_VOID) begin
                got = 1'b0;
                if (pfree[2'(i)]) begin
                    psel[2'(i)]  = ICODE[i];
                    pfree[2'(i)] = 1'b0;
                    got          = 1'b1;
                end
                for (int j = 0; j < 4; j++) begin
                    if (!got && pfree[2'(j)]) begin
                        psel[2'(j)]  = ICODE[i];
                        pfree[2'(j)] = 1'b0;
                        got          = 1'b1;
                    end
                end
            end
        end
    end

`ifdef PI_ARB_LFSR_EN
    localparam logic [LFSR_W-1:0] LFSR_INIT =
        (LFSR_SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : LFSR_SEED;
    localparam logic SWAP_INIT = LFSR_INIT[0];
    logic [LFSR_W-1:0] lfsr;

    // Galois LFSR, stepped only on cycles that actually use an up slot
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_INIT;
        else if (en && up_active)
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    end
    assign swap_cur = lfsr[0];
`else
    localparam logic SWAP_INIT = 1'b1;
    logic tog;

    // toggle swap source, flipped only on cycles that actually use an up slot
    always_ff @(posedge clk) begin
        if (reset)
            tog <= 1'b1;
        else if (en && up_active)
            tog <= ~tog;
    end
    assign swap_cur = tog;
`endif

    // output registers, fairness counters and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_l    <= S_LEFT;
            sel_r    <= S_RIGHT;
            sel_ul   <= S_UPL;
            sel_ur   <= S_UPR;
            defl_vec <= '0;
            swap     <= SWAP_INIT;
            cnt_l    <= '0;
            cnt_r    <= '0;
            rr_ptr   <= 1'b0;
        end else if (en) begin
            sel_l    <= psel[P_L];
            sel_r    <= psel[P_R];
            sel_ul   <= swap_cur ? psel[P_U1] : psel[P_U2];
            sel_ur   <= swap_cur ? psel[P_U2] : psel[P_U1];
            defl_vec <= {defl[0], defl[1], defl[2], defl[3]};
            swap     <= swap_cur;
            cnt_l    <= defl[0] ? ((cnt_l == CNT_MAX) ? cnt_l : cnt_l + 1'b1) : '0;
            cnt_r    <= defl[1] ? ((cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1) : '0;
            if (defl[0] | defl[1])
                rr_ptr <= ~rr_ptr;
        end
    end

endmodule
